// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared encodings for the dev_timer countdown timer
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/dev_timer.sv
// rtl/dev_timer.sv - memory-mapped countdown timer with maskable interrupt
module dev_timer
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  DEV_Addr,
  input  logic [31:0] DEV_WD,
  input  logic        DEV_we,
  output logic [31:0] DEV_RD,
  output logic        DEV_IRQ
);

  state_t      state, state_nxt;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count, count_nxt;
  logic        irq_pend, pend_nxt;
  logic        en_clr;
  logic        en;
  logic [1:0]  mode;
  logic        ctrl_wr, preset_wr;

  assign en        = ctrl[CTRL_EN];
  assign mode      = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
  assign ctrl_wr   = DEV_we && (DEV_Addr == OFF_CTRL);
  assign preset_wr = DEV_we && (DEV_Addr == OFF_PRESET);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    pend_nxt  = irq_pend;
    en_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else begin
          count_nxt = preset;
          state_nxt = ST_CNT;
        end
      end
      ST_CNT: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          count_nxt = 32'd0;
          pend_nxt  = 1'b1;
          state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        if (en && mode == MODE_RELOAD) begin
          pend_nxt  = 1'b0;
          state_nxt = ST_LOAD;
        end else begin
          en_clr    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A software CTRL write overrides the FSM's own EN clear and pending update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (ctrl_wr) begin
        ctrl     <= DEV_WD[3:0];
        irq_pend <= 1'b0;
      end else begin
        if (en_clr) ctrl[CTRL_EN] <= 1'b0;
        irq_pend <= pend_nxt;
      end
      if (preset_wr) preset <= DEV_WD;
    end
  end

  always_comb begin
    DEV_RD = 32'd0;
    case (DEV_Addr)
      OFF_CTRL:   DEV_RD = {28'd0, ctrl};
      OFF_PRESET: DEV_RD = preset;
      OFF_COUNT:  DEV_RD = count;
      default:    DEV_RD = 32'd0;
    endcase
  end

  assign DEV_IRQ = ctrl[CTRL_IM] & irq_pend;

endmodule

// File: tb/tb_dev_timer.sv
// tb/tb_dev_timer.sv - self-checking bench for dev_timer
module tb_dev_timer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  DEV_Addr;
  logic [31:0] DEV_WD;
  logic        DEV_we;
  logic [31:0] DEV_RD;
  logic        DEV_IRQ;

  int errors = 0;
  int checks = 0;

  dev_timer dut (
    .clk(clk), .rst_n(rst_n), .DEV_Addr(DEV_Addr), .DEV_WD(DEV_WD),
    .DEV_we(DEV_we), .DEV_RD(DEV_RD), .DEV_IRQ(DEV_IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timer: the timer is either idle, about to reload, counting,
  // or has just expired; each edge applies the countdown rules, then bus writes.
  int          m_phase;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  bit          m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_ctrl = 4'd0; m_preset = 0; m_count = 0; m_pend = 0;
    end else begin
      bit          on;
      bit          reload;
      int          ph;
      logic [31:0] cn;
      bit          pd;
      bit          drop_en;
      on = m_ctrl[0];
      reload = (m_ctrl[2:1] == 2'b01);
      ph = m_phase; cn = m_count; pd = m_pend; drop_en = 0;
      if (m_phase == 0) begin
        if (on) ph = 1;
      end else if (m_phase == 1) begin
        if (on) begin cn = m_preset; ph = 2; end else ph = 0;
      end else if (m_phase == 2) begin
        if (!on) ph = 0;
        else if (m_count >= 2) cn = m_count - 1;
        else begin cn = 0; pd = 1; ph = 3; end
      end else begin
        if (on && reload) begin pd = 0; ph = 1; end
        else begin drop_en = 1; ph = 0; end
      end
      m_phase = ph; m_count = cn; m_pend = pd;
      if (drop_en) m_ctrl[0] = 1'b0;
      if (DEV_we && DEV_Addr == 2'd0) begin m_ctrl = DEV_WD[3:0]; m_pend = 0; end
      if (DEV_we && DEV_Addr == 2'd1) m_preset = DEV_WD;
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0: return {28'd0, m_ctrl};
      2'd1: return m_preset;
      2'd2: return m_count;
      default: return 32'd0;
    endcase
  endfunction

  always begin
    @(posedge clk);
    #1;
    checks++;
    if (DEV_IRQ !== (m_ctrl[3] & m_pend)) begin
      errors++;
      $display("FAIL model_irq t=%0t got=%b want=%b", $time, DEV_IRQ, m_ctrl[3] & m_pend);
    end
    checks++;
    if (DEV_RD !== model_rd(DEV_Addr)) begin
      errors++;
      $display("FAIL model_rd t=%0t addr=%0d got=%h want=%h", $time, DEV_Addr, DEV_RD, model_rd(DEV_Addr));
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    DEV_Addr = a; DEV_WD = d; DEV_we = 1'b1;
    @(negedge clk);
    DEV_we = 1'b0;
  endtask

  task automatic expect_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    DEV_Addr = a;
    #1;
    checks++;
    if (DEV_RD !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, DEV_RD, exp);
    end
  endtask

  task automatic expect_irq(input logic exp, input string name);
    checks++;
    if (DEV_IRQ !== exp) begin
      errors++;
      $display("FAIL %s irq got=%b want=%b", name, DEV_IRQ, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int pulses[$];
  int irq_seen;

  initial begin
    rst_n = 1'b0; DEV_Addr = 2'd0; DEV_WD = 32'd0; DEV_we = 1'b0;
    cycles(2);
    expect_rd(2'd0, 32'd0, "rst_ctrl");
    expect_rd(2'd1, 32'd0, "rst_preset");
    expect_rd(2'd2, 32'd0, "rst_count");
    expect_irq(1'b0, "rst");
    rst_n = 1'b1;

    // reset mid-count with COUNT=5
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h9);
    cycles(5);
    expect_rd(2'd2, 32'd5, "midcount_5");
    #2 rst_n = 1'b0;
    #1;
    expect_rd(2'd2, 32'd0, "async_rst_count");
    expect_rd(2'd0, 32'd0, "async_rst_ctrl");
    expect_rd(2'd1, 32'd0, "async_rst_preset");
    expect_irq(1'b0, "async_rst");
    cycles(2);
    rst_n = 1'b1;
    irq_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (DEV_IRQ) irq_seen++;
    end
    checks++;
    if (irq_seen != 0) begin errors++; $display("FAIL post_rst_irq got=%0d want=0", irq_seen); end

    // one-shot, PRESET=4
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    cycles(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      expect_rd(2'd2, 32'(4 - i), "oneshot_count");
    end
    expect_irq(1'b0, "oneshot_before");
    cycles(1);
    expect_irq(1'b1, "oneshot_t6");
    cycles(1);
    expect_rd(2'd0, 32'h8, "oneshot_ctrl_en_cleared");
    expect_irq(1'b1, "oneshot_held");
    cycles(3);
    expect_irq(1'b1, "oneshot_still_held");
    wr(2'd0, 32'h8);
    expect_irq(1'b0, "oneshot_ack");

    // auto-reload, PRESET=3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    pulses.delete();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (DEV_IRQ) pulses.push_back(i);
    end
    checks++;
    if (pulses.size() < 5) begin errors++; $display("FAIL reload_pulse_count got=%0d want>=5", pulses.size()); end
    for (int i = 1; i < pulses.size(); i++) begin
      checks++;
      if (pulses[i] - pulses[i-1] != 5) begin
        errors++; $display("FAIL reload_period got=%0d want=5", pulses[i] - pulses[i-1]);
      end
    end
    wr(2'd0, 32'h0);
    cycles(2);

    // masked expiry, PRESET=2
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    cycles(6);
    expect_rd(2'd0, 32'h0, "mask_en_cleared");
    expect_rd(2'd2, 32'd0, "mask_count_zero");
    expect_irq(1'b0, "mask_quiet");
    wr(2'd0, 32'h8);
    expect_irq(1'b0, "mask_unmask_cleared");
    cycles(2);
    expect_irq(1'b0, "mask_unmask_later");
    wr(2'd0, 32'h0);

    // disable mid-count, PRESET=10
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    cycles(4);
    wr(2'd0, 32'h0);
    cycles(3);
    expect_rd(2'd2, 32'd6, "disable_frozen");
    expect_irq(1'b0, "disable_noirq");
    wr(2'd0, 32'h9);
    cycles(2);
    expect_rd(2'd2, 32'd10, "reenable_reload");
    wr(2'd0, 32'h0);
    cycles(2);

    // PRESET=0 fires 3 cycles after enable
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    cycles(2);
    expect_irq(1'b0, "preset0_t2");
    cycles(1);
    expect_irq(1'b1, "preset0_t3");
    wr(2'd0, 32'h0);

    // reserved and read-only offsets ignore writes
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd3, 32'hA5A5_A5A5);
    @(negedge clk);
    expect_rd(2'd0, 32'h0, "ro_ctrl");
    expect_rd(2'd1, 32'h0, "ro_preset");
    expect_rd(2'd2, 32'h0, "ro_count");
    expect_rd(2'd3, 32'h0, "off3_read");

    // CTRL write on the INT edge wins
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    cycles(3);
    wr(2'd0, 32'h9);
    expect_rd(2'd0, 32'h9, "int_edge_ctrl_kept");
    expect_irq(1'b0, "int_edge_irq_cleared");
    wr(2'd0, 32'h0);
    cycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
